// File: rtl/spectrum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spectrum_pkg
//  Description : Shared fixed-point defaults, sweep FSM state type and
//                saturating arithmetic helpers for the spectrum display.
//  Revision    : 1.0 - initial release
// ============================================================================
package spectrum_pkg;

    // Default fractional/integer bit splits of the stored height and speed.
    localparam int HFP_DEF     = 4;
    localparam int SFP_DEF     = 5;
    localparam int SPD_INT_DEF = 2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sweep_state_t;

    // Unsigned add clamped to max_val.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

    // Unsigned subtract clamped at zero.
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/peak_state_ram.sv
`default_nettype none
// ============================================================================
//  Module      : peak_state_ram
//  Description : Simple dual-port RAM holding the per-bin peak state word,
//                one write port and one registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module peak_state_ram #(
    parameter int DEPTH  = 800,
    parameter int WIDTH  = 22,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; data appears the cycle after rd_en.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/peak_hold_decay.sv
`default_nettype none
// ============================================================================
//  Module      : peak_hold_decay
//  Description : Per-bin, per-channel peak-hold marker engine. Streams bar
//                heights in, returns the falling top marker two cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module peak_hold_decay
    import spectrum_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int BINS     = 400,
    parameter int BAR_W    = 7,
    parameter int HFP      = HFP_DEF,
    parameter int SFP      = SFP_DEF,
    parameter int SPD_INT  = SPD_INT_DEF,
    parameter int HOLD_W   = 4,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int BIN_W   = $clog2(BINS)
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              NewFrame,
    input  logic              In_Valid,
    input  logic [CH_W-1:0]   In_Ch,
    input  logic [BAR_W-1:0]  In_Bar,
    input  logic [2:0]        FallAccel,
    input  logic [HOLD_W-1:0] HoldFrames,
    output logic              Busy,
    output logic              Out_Valid,
    output logic [CH_W-1:0]   Out_Ch,
    output logic [BIN_W-1:0]  Out_Bin,
    output logic [BAR_W-1:0]  Out_Top,
    output logic              Overrun
);

    localparam int CNT_W  = $clog2(BINS + 1);
    localparam int DEPTH  = CHANNELS * BINS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW     = BAR_W + HFP;
    localparam int SPD_W  = SPD_INT + SFP;
    localparam int SW     = HW + SPD_W + HOLD_W;

    localparam logic [CNT_W-1:0]  BINS_CNT  = CNT_W'(BINS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [31:0]       SPD_MAX   = 32'((1 << SPD_W) - 1);

    typedef struct packed {
        logic [HW-1:0]     height;
        logic [SPD_W-1:0]  speed;
        logic [HOLD_W-1:0] hold;
    } peak_state_t;

    sweep_state_t      state, state_next;
    logic [ADDR_W-1:0] init_addr;
    logic              running;

    logic [CNT_W-1:0]  bin_cnt [CHANNELS];
    logic [CNT_W-1:0]  cur_cnt, cnt_eff;
    logic              ch_ok, slot_free, accept, drop;
    logic [ADDR_W-1:0] rd_addr;

    logic              p1_valid;
    logic [ADDR_W-1:0] p1_addr;
    logic [CH_W-1:0]   p1_ch;
    logic [BIN_W-1:0]  p1_bin;
    logic [BAR_W-1:0]  p1_bar;
    logic [HOLD_W-1:0] p1_hold;
    logic [2:0]        p1_accel;

    logic [SW-1:0]     rd_word, wr_word;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    peak_state_t       cur_st, new_st;
    logic [SPD_W-1:0]  step;

    assign running = (state == ST_RUN);
    assign Busy    = (state == ST_INIT);

    // Sweep state register and init address; reset restarts the sweep at 0.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_addr <= init_addr + 1'b1;
            end
        end
    end

    // Leave INIT once the last address has been cleared.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_addr == LAST_ADDR) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // Out-of-range channel numbers only exist when CHANNELS is not a power of 2.
    generate
        if ((1 << CH_W) == CHANNELS) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_partial
            assign ch_ok = (In_Ch < CH_W'(CHANNELS));
        end
    endgenerate

    // A frame restart makes this sample bin 0 regardless of the old count.
    assign cur_cnt   = ch_ok ? bin_cnt[In_Ch] : '0;
    assign cnt_eff   = NewFrame ? '0 : cur_cnt;
    assign slot_free = (cnt_eff != BINS_CNT);
    assign accept    = running & In_Valid & ch_ok & slot_free;
    assign drop      = running & In_Valid & ~(ch_ok & slot_free);
    assign rd_addr   = ADDR_W'(32'(In_Ch) * BINS + 32'(cnt_eff));

    // Per-channel bin counters.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < CHANNELS; i++) bin_cnt[i] <= '0;
        end else if (running) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (accept && (In_Ch == CH_W'(i))) begin
                    bin_cnt[i] <= cnt_eff + 1'b1;
                end else if (NewFrame) begin
                    bin_cnt[i] <= '0;
                end
            end
        end
    end

    // Sticky overrun flag; a drop in the restart cycle still flags.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Overrun <= 1'b0;
        end else if (running) begin
            if (drop) begin
                Overrun <= 1'b1;
            end else if (NewFrame) begin
                Overrun <= 1'b0;
            end
        end
    end

    // Carry sample context alongside the RAM read.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            p1_valid <= 1'b0;
            p1_addr  <= '0;
            p1_ch    <= '0;
            p1_bin   <= '0;
            p1_bar   <= '0;
            p1_hold  <= '0;
            p1_accel <= '0;
        end else begin
            p1_valid <= accept;
            if (accept) begin
                p1_addr  <= rd_addr;
                p1_ch    <= In_Ch;
                p1_bin   <= BIN_W'(cnt_eff);
                p1_bar   <= In_Bar;
                p1_hold  <= HoldFrames;
                p1_accel <= FallAccel;
            end
        end
    end

    assign cur_st = rd_word;

    // Capture / hold / fall update of the returned state word.
    always_comb begin
        new_st = cur_st;
        step   = '0;
        if (p1_bar >= cur_st.height[HW-1:HFP]) begin
            new_st.height = HW'(p1_bar) << HFP;
            new_st.speed  = '0;
            new_st.hold   = p1_hold;
        end else if (cur_st.hold != '0) begin
            new_st.hold = cur_st.hold - 1'b1;
        end else begin
            step          = cur_st.speed >> (SFP - HFP);
            new_st.height = HW'(sat_sub(32'(cur_st.height), 32'(step)));
            new_st.speed  = SPD_W'(sat_add(32'(cur_st.speed), 32'(p1_accel), SPD_MAX));
            new_st.hold   = '0;
        end
    end

    // The sweep owns the write port until it completes.
    assign wr_en   = Busy ? 1'b1 : p1_valid;
    assign wr_addr = Busy ? init_addr : p1_addr;
    assign wr_word = Busy ? '0 : new_st;

    peak_state_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (SW),
        .ADDR_W (ADDR_W)
    ) u_state_ram (
        .clk     (Clock),
        .rd_en   (accept),
        .rd_addr (rd_addr),
        .rd_data (rd_word),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_word)
    );

    // Result register; payload holds its value between results.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_Valid <= 1'b0;
            Out_Ch    <= '0;
            Out_Bin   <= '0;
            Out_Top   <= '0;
        end else begin
            Out_Valid <= p1_valid;
            if (p1_valid) begin
                Out_Ch  <= p1_ch;
                Out_Bin <= p1_bin;
                Out_Top <= new_st.height[HW-1:HFP];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peak_hold_decay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peak_hold_decay
//  Description : Self-checking bench for peak_hold_decay with a behavioural
//                model feeding an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_peak_hold_decay;

    localparam int CHANNELS = 2;
    localparam int BINS     = 400;
    localparam int DEPTH    = CHANNELS * BINS;

    logic       Clock, Reset_n, NewFrame, In_Valid;
    logic [0:0] In_Ch;
    logic [6:0] In_Bar;
    logic [2:0] FallAccel;
    logic [3:0] HoldFrames;
    logic       Busy, Out_Valid, Overrun;
    logic [0:0] Out_Ch;
    logic [8:0] Out_Bin;
    logic [6:0] Out_Top;

    peak_hold_decay #(
        .CHANNELS (CHANNELS),
        .BINS     (BINS),
        .BAR_W    (7),
        .HFP      (4),
        .SFP      (5),
        .SPD_INT  (2),
        .HOLD_W   (4)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .NewFrame   (NewFrame),
        .In_Valid   (In_Valid),
        .In_Ch      (In_Ch),
        .In_Bar     (In_Bar),
        .FallAccel  (FallAccel),
        .HoldFrames (HoldFrames),
        .Busy       (Busy),
        .Out_Valid  (Out_Valid),
        .Out_Ch     (Out_Ch),
        .Out_Bin    (Out_Bin),
        .Out_Top    (Out_Top),
        .Overrun    (Overrun)
    );

    typedef struct {
        int ch;
        int bin;
        int top;
        int pc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_out   = 0;
    int   pcnt    = 0;
    int   mh[DEPTH];
    int   ms[DEPTH];
    int   mk[DEPTH];
    int   mcnt[CHANNELS];

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) pcnt <= pcnt + 1;

    // Scoreboard: every result must match the oldest expectation, on time.
    always @(negedge Clock) begin
        if (Out_Valid === 1'b1) begin
            n_out++;
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_result: got ch=%0d bin=%0d top=%0d, expected no result",
                         Out_Ch, Out_Bin, Out_Top);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (Out_Ch !== 1'(e.ch) || Out_Bin !== 9'(e.bin) ||
                    Out_Top !== 7'(e.top) || pcnt !== e.pc) begin
                    $display("FAIL result: got ch=%0d bin=%0d top=%0d edge=%0d, expected ch=%0d bin=%0d top=%0d edge=%0d",
                             Out_Ch, Out_Bin, Out_Top, pcnt, e.ch, e.bin, e.top, e.pc);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) begin
            mh[i] = 0;
            ms[i] = 0;
            mk[i] = 0;
        end
        foreach (mcnt[i]) mcnt[i] = 0;
    endtask

    // Drive one sample for the next capturing edge and queue its expected result.
    task automatic drive_sample(input int ch, input int bar, input bit nf,
                                input int hold, input int acc);
        int   a;
        int   step;
        exp_t e;
        @(posedge Clock);
        #1;
        In_Valid   = 1'b1;
        In_Ch      = 1'(ch);
        In_Bar     = 7'(bar);
        NewFrame   = nf;
        HoldFrames = 4'(hold);
        FallAccel  = 3'(acc);
        if (nf) foreach (mcnt[i]) mcnt[i] = 0;
        if (mcnt[ch] != BINS) begin
            a = ch * BINS + mcnt[ch];
            if (bar >= (mh[a] >> 4)) begin
                mh[a] = bar * 16;
                ms[a] = 0;
                mk[a] = hold;
            end else if (mk[a] != 0) begin
                mk[a] = mk[a] - 1;
            end else begin
                step  = ms[a] >> 1;
                mh[a] = (mh[a] > step) ? mh[a] - step : 0;
                ms[a] = (ms[a] + acc > 127) ? 127 : ms[a] + acc;
                mk[a] = 0;
            end
            e.ch  = ch;
            e.bin = mcnt[ch];
            e.top = mh[a] >> 4;
            e.pc  = pcnt + 2;
            sb.push_back(e);
            mcnt[ch]++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
            In_Valid = 1'b0;
            NewFrame = 1'b0;
        end
    endtask

    task automatic wait_drain(output int left);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge Clock);
        #1;
        left = sb.size();
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clock);
            if (Busy === 1'b1) n++;
            else break;
        end
    endtask

    task automatic test_reset();
        int n;
        int left;
        #2 Reset_n = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        n_total++; if (Out_Valid !== 1'b0) $display("FAIL rst_out_valid: got %b, expected 0", Out_Valid); else n_pass++;
        n_total++; if (Out_Top !== 7'd0)   $display("FAIL rst_out_top: got %0d, expected 0", Out_Top); else n_pass++;
        n_total++; if (Out_Ch !== 1'b0)    $display("FAIL rst_out_ch: got %0d, expected 0", Out_Ch); else n_pass++;
        n_total++; if (Out_Bin !== 9'd0)   $display("FAIL rst_out_bin: got %0d, expected 0", Out_Bin); else n_pass++;
        n_total++; if (Overrun !== 1'b0)   $display("FAIL rst_overrun: got %b, expected 0", Overrun); else n_pass++;
        n_total++; if (Busy !== 1'b1)      $display("FAIL rst_busy: got %b, expected 1", Busy); else n_pass++;
        Reset_n = 1'b1;
        wait_busy(n);
        n_total++; if (n !== DEPTH) $display("FAIL busy_cycles: got %0d, expected %0d", n, DEPTH); else n_pass++;
        drive_sample(0, 0, 1'b1, 0, 0);
        idle(1);
        wait_drain(left);
        n_total++; if (left !== 0) $display("FAIL reset_drain: got %0d pending, expected 0", left); else n_pass++;
    endtask

    task automatic test_hold_fall();
        int left;
        for (int f = 0; f < 12; f++) begin
            drive_sample(0, (f == 0) ? 100 : 0, 1'b1, 2, 4);
            idle(2);
        end
        wait_drain(left);
        n_total++; if (left !== 0) $display("FAIL hold_drain: got %0d pending, expected 0", left); else n_pass++;
        n_total++; if (Out_Top !== 7'(mh[0] >> 4)) $display("FAIL hold_last_top: got %0d, expected %0d", Out_Top, mh[0] >> 4); else n_pass++;
    endtask

    task automatic test_saturate();
        int left;
        for (int f = 0; f < 60; f++) begin
            drive_sample(1, (f == 0) ? 120 : 0, 1'b1, 0, 7);
            idle(1);
        end
        wait_drain(left);
        n_total++; if (left !== 0) $display("FAIL sat_drain: got %0d pending, expected 0", left); else n_pass++;
        n_total++; if (Out_Top !== 7'd0) $display("FAIL sat_floor: got %0d, expected 0", Out_Top); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int left;
        int n0;
        n0 = n_out;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < BINS; b++) begin
                drive_sample(0, (b * 7 + f * 50) % 128, (b == 0), 1, 3);
                drive_sample(1, (b * 13 + 5 + f * 3) % 128, 1'b0, 1, 3);
            end
        end
        idle(1);
        wait_drain(left);
        n_total++; if (left !== 0) $display("FAIL b2b_drain: got %0d pending, expected 0", left); else n_pass++;
        n_total++; if (n_out - n0 !== 4 * BINS) $display("FAIL b2b_count: got %0d results, expected %0d", n_out - n0, 4 * BINS); else n_pass++;
    endtask

    task automatic test_overrun();
        int left;
        int n0;
        n0 = n_out;
        for (int b = 0; b < BINS; b++) drive_sample(0, (b * 3) % 128, (b == 0), 0, 1);
        idle(1);
        @(negedge Clock);
        n_total++; if (Overrun !== 1'b0) $display("FAIL ovr_full_frame: got %b, expected 0", Overrun); else n_pass++;
        drive_sample(0, 90, 1'b0, 0, 1);
        idle(1);
        @(negedge Clock);
        n_total++; if (Overrun !== 1'b1) $display("FAIL ovr_set: got %b, expected 1", Overrun); else n_pass++;
        // The other channel still has room in this frame.
        drive_sample(1, 33, 1'b0, 0, 1);
        idle(1);
        wait_drain(left);
        n_total++; if (left !== 0) $display("FAIL ovr_drain: got %0d pending, expected 0", left); else n_pass++;
        n_total++; if (n_out - n0 !== BINS + 1) $display("FAIL ovr_count: got %0d results, expected %0d", n_out - n0, BINS + 1); else n_pass++;
        n_total++; if (Overrun !== 1'b1) $display("FAIL ovr_sticky: got %b, expected 1", Overrun); else n_pass++;
        drive_sample(0, 77, 1'b1, 0, 1);
        idle(1);
        @(negedge Clock);
        n_total++; if (Overrun !== 1'b0) $display("FAIL ovr_clear: got %b, expected 0", Overrun); else n_pass++;
        wait_drain(left);
        n_total++; if (left !== 0) $display("FAIL ovr_reuse_drain: got %0d pending, expected 0", left); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        int left;
        for (int b = 0; b < 10; b++) drive_sample(0, 60 + b, (b == 0), 1, 2);
        #2 Reset_n = 1'b0;
        #1;
        n_total++; if (Out_Valid !== 1'b0) $display("FAIL mid_out_valid: got %b, expected 0", Out_Valid); else n_pass++;
        n_total++; if (Out_Top !== 7'd0)   $display("FAIL mid_out_top: got %0d, expected 0", Out_Top); else n_pass++;
        n_total++; if (Out_Bin !== 9'd0)   $display("FAIL mid_out_bin: got %0d, expected 0", Out_Bin); else n_pass++;
        n_total++; if (Busy !== 1'b1)      $display("FAIL mid_busy: got %b, expected 1", Busy); else n_pass++;
        sb.delete();
        reset_model();
        repeat (2) @(posedge Clock);
        #1;
        Reset_n  = 1'b1;
        // Traffic during the sweep must be ignored.
        In_Valid = 1'b1;
        NewFrame = 1'b1;
        In_Ch    = 1'b0;
        In_Bar   = 7'd99;
        wait_busy(n);
        In_Valid = 1'b0;
        NewFrame = 1'b0;
        n_total++; if (n !== DEPTH) $display("FAIL mid_busy_cycles: got %0d, expected %0d", n, DEPTH); else n_pass++;
        n_total++; if (Overrun !== 1'b0) $display("FAIL mid_overrun: got %b, expected 0", Overrun); else n_pass++;
        drive_sample(0, 50, 1'b0, 3, 2);
        idle(1);
        wait_drain(left);
        n_total++; if (left !== 0) $display("FAIL mid_drain: got %0d pending, expected 0", left); else n_pass++;
    endtask

    initial begin
        Reset_n    = 1'b1;
        NewFrame   = 1'b0;
        In_Valid   = 1'b0;
        In_Ch      = 1'b0;
        In_Bar     = 7'd0;
        FallAccel  = 3'd0;
        HoldFrames = 4'd0;
        reset_model();
        test_reset();
        test_hold_fall();
        test_saturate();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
